cop_wb_queue: RTL and testbench

//  Result write-back queue directly downstream of the custom-instruction co-processor interface (SIKEp434 ISE, RV64).

---
 rtl/cop_wb_queue.sv | 104 ++++++++++
 tb/tb_cop_wb_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_wb_queue.sv
// Write-back queue between the co-processor result port and the core write-back port.
// Small FIFO of {rd, data} entries with back-pressure, sticky overflow flag and RAW hazard detection.
module cop_wb_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            cop_clk,
    input  logic            cop_rst,
    input  logic            cop_valid,
    input  logic [31:0]     cop_insn,
    input  logic            cop_wr,
    input  logic [XLEN-1:0] cop_rd,
    output logic            cop_rdywr,
    output logic            raw_hazard,
    output logic            wb_valid,
    output logic [4:0]      wb_idx,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_ready,
    output logic            err_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      idx_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic [4:0] ins_rd;
    logic [4:0] ins_rs1;
    logic [4:0] ins_rs2;
    logic       enq;
    logic       deq;
    logic       raw_hit;

    assign ins_rd  = cop_insn[11:7];
    assign ins_rs1 = cop_insn[19:15];
    assign ins_rs2 = cop_insn[24:20];

    // Handshakes: a result transfers when cop_wr & cop_rdywr, a head entry when
    // wb_valid & wb_ready; both ready/valid flags come from registered state only.
    assign cop_rdywr = (count_q != FULL);
    assign wb_valid  = (count_q != '0);
    assign wb_idx    = wb_valid ? idx_q[rd_ptr_q]  : 5'd0;
    assign wb_data   = wb_valid ? data_q[rd_ptr_q] : '0;
    assign err_ovf   = err_q;

    assign enq = cop_wr & cop_rdywr & (ins_rd != 5'd0);
    assign deq = wb_valid & wb_ready;

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (deq) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PW'(1);
            end
            if (enq) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A full queue never lets a result through, not even when the head leaves.
            if (cop_wr && !cop_rdywr && (ins_rd != 5'd0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge cop_clk) begin
        if (!cop_rst && enq) begin
            idx_q[wr_ptr_q]  <= ins_rd;
            data_q[wr_ptr_q] <= cop_rd;
        end
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (idx_q[i] != 5'd0) &&
                ((idx_q[i] == ins_rs1) || (idx_q[i] == ins_rs2))) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign raw_hazard = cop_valid & raw_hit;

endmodule

// File: tb/tb_cop_wb_queue.sv
// Directed bench for cop_wb_queue: a per-cycle queue model on the falling edge checks every
// output, plus directed point checks for reset, back-pressure, x0 discard, hazards and throughput.
module tb_cop_wb_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;
    localparam int EW    = 5 + XLEN;

    logic            cop_clk;
    logic            cop_rst;
    logic            cop_valid;
    logic [31:0]     cop_insn;
    logic            cop_wr;
    logic [XLEN-1:0] cop_rd;
    logic            cop_rdywr;
    logic            raw_hazard;
    logic            wb_valid;
    logic [4:0]      wb_idx;
    logic [XLEN-1:0] wb_data;
    logic            wb_ready;
    logic            err_ovf;

    cop_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .cop_clk    (cop_clk),
        .cop_rst    (cop_rst),
        .cop_valid  (cop_valid),
        .cop_insn   (cop_insn),
        .cop_wr     (cop_wr),
        .cop_rd     (cop_rd),
        .cop_rdywr  (cop_rdywr),
        .raw_hazard (raw_hazard),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .err_ovf    (err_ovf)
    );

    // ---------------- clock / reset ----------------
    initial cop_clk = 1'b0;
    always #5 cop_clk = ~cop_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic          m_err;
    logic          mon_en;
    int            n_tests;
    int            n_fail;
    int            n_deliv;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state is compared first, then advanced with the inputs that the next edge will see.
    always @(negedge cop_clk) begin
        if (mon_en) begin
            int            m_cnt;
            logic          m_rdy;
            logic          m_haz;
            logic [4:0]    rd_f;
            logic [4:0]    rs1_f;
            logic [4:0]    rs2_f;
            m_cnt = exp_q.size();
            m_rdy = (m_cnt != DEPTH);
            rd_f  = cop_insn[11:7];
            rs1_f = cop_insn[19:15];
            rs2_f = cop_insn[24:20];
            m_haz = 1'b0;
            foreach (exp_q[i]) begin
                if (exp_q[i][EW-1 -: 5] == rs1_f || exp_q[i][EW-1 -: 5] == rs2_f) m_haz = 1'b1;
            end
            m_haz = m_haz & cop_valid;
            chk("mon_rdywr", 128'(cop_rdywr), 128'(m_rdy));
            chk("mon_wb_valid", 128'(wb_valid), 128'(m_cnt != 0));
            chk("mon_head", 128'({wb_idx, wb_data}), (m_cnt != 0) ? 128'(exp_q[0]) : 128'(0));
            chk("mon_err_ovf", 128'(err_ovf), 128'(m_err));
            chk("mon_raw_hazard", 128'(raw_hazard), 128'(m_haz));
            if (cop_rst) begin
                exp_q.delete();
                m_err = 1'b0;
            end else begin
                if (m_cnt != 0 && wb_ready) begin
                    void'(exp_q.pop_front());
                    n_deliv++;
                end
                if (cop_wr && rd_f != 5'd0) begin
                    if (m_rdy) exp_q.push_back({rd_f, cop_rd});
                    else       m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge cop_clk);
        #1;
    endtask

    function automatic logic [31:0] insn(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0001011};
    endfunction

    task automatic put(input logic [4:0] rd, input logic [XLEN-1:0] d);
        cop_wr   = 1'b1;
        cop_insn = insn(rd, 5'd0, 5'd0);
        cop_rd   = d;
    endtask

    task automatic idle();
        cop_wr    = 1'b0;
        cop_valid = 1'b0;
        cop_insn  = 32'd0;
        cop_rd    = '0;
    endtask

    // ---------------- directed steps ----------------
    initial begin
        int base;
        n_tests = 0; n_fail = 0; n_deliv = 0;
        m_err = 1'b0; mon_en = 1'b0;
        wb_ready = 1'b0;
        idle();

        // 1 reset held two cycles with a result offered
        cop_rst = 1'b1;
        put(5'd5, 64'hDEAD);
        cyc(); cyc();
        cop_rst = 1'b0;
        idle();
        chk("rst_wb_valid", 128'(wb_valid), 128'(0));
        chk("rst_wb_idx", 128'(wb_idx), 128'(0));
        chk("rst_wb_data", 128'(wb_data), 128'(0));
        chk("rst_rdywr", 128'(cop_rdywr), 128'(1));
        chk("rst_err_ovf", 128'(err_ovf), 128'(0));
        mon_en = 1'b1;

        // 2 single result, latency one, held while not ready
        put(5'd5, 64'h0123_4567_89AB_CDEF);
        cyc();
        idle();
        chk("single_valid", 128'(wb_valid), 128'(1));
        chk("single_idx", 128'(wb_idx), 128'(5));
        chk("single_data", 128'(wb_data), 128'(64'h0123_4567_89AB_CDEF));
        cyc(); cyc();
        chk("single_hold_data", 128'(wb_data), 128'(64'h0123_4567_89AB_CDEF));
        wb_ready = 1'b1;
        cyc();
        wb_ready = 1'b0;
        chk("single_drained", 128'(wb_valid), 128'(0));

        // 3 fill, back-pressure and overflow
        put(5'd3, 64'd1); cyc();
        put(5'd4, 64'd2); cyc();
        chk("full_rdywr", 128'(cop_rdywr), 128'(0));
        put(5'd9, 64'd3); cyc();
        idle();
        chk("ovf_err", 128'(err_ovf), 128'(1));
        chk("ovf_head_idx", 128'(wb_idx), 128'(3));
        chk("ovf_head_data", 128'(wb_data), 128'(1));

        // 4 full with dequeue and offered result in the same cycle
        wb_ready = 1'b1;
        put(5'd10, 64'h10);
        cyc();
        chk("fdq_rdywr", 128'(cop_rdywr), 128'(1));
        chk("fdq_head_idx", 128'(wb_idx), 128'(4));
        cyc();
        idle();
        chk("retry_idx", 128'(wb_idx), 128'(10));
        chk("retry_data", 128'(wb_data), 128'(64'h10));
        cyc();
        wb_ready = 1'b0;
        chk("retry_empty", 128'(wb_valid), 128'(0));

        // 5 x0 discard, then hazards against a queued x7
        put(5'd0, 64'h55); cyc();
        idle();
        chk("x0_no_valid", 128'(wb_valid), 128'(0));
        put(5'd7, 64'h77);
        cop_valid = 1'b1;
        cop_insn  = insn(5'd7, 5'd7, 5'd0);
        #1;
        chk("haz_same_cycle_enq", 128'(raw_hazard), 128'(0));
        cyc();
        cop_wr   = 1'b0;
        cop_insn = insn(5'd1, 5'd0, 5'd7);
        #1;
        chk("haz_rs2", 128'(raw_hazard), 128'(1));
        cop_insn = insn(5'd1, 5'd0, 5'd0);
        #1;
        chk("haz_zero_regs", 128'(raw_hazard), 128'(0));
        cop_insn = insn(5'd1, 5'd7, 5'd2);
        wb_ready = 1'b1;
        #1;
        chk("haz_during_deq", 128'(raw_hazard), 128'(1));
        cyc();
        wb_ready = 1'b0;
        idle();

        // reset mid-operation drops queued entries and the sticky error
        put(5'd12, 64'hC0FFEE); cyc();
        idle();
        cop_rst = 1'b1; cyc();
        cop_rst = 1'b0;
        chk("midrst_valid", 128'(wb_valid), 128'(0));
        chk("midrst_err", 128'(err_ovf), 128'(0));

        // 6 back-to-back throughput across pointer wrap
        wb_ready = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 100; i++) begin
            put(5'((i % 31) + 1), {$urandom(), $urandom()});
            cyc();
            chk("thr_valid", 128'(wb_valid), 128'(1));
            chk("thr_rdywr", 128'(cop_rdywr), 128'(1));
        end
        idle();
        cyc();
        chk("thr_delivered", 128'(n_deliv - base), 128'(100));
        chk("thr_err_ovf", 128'(err_ovf), 128'(0));
        chk("thr_empty", 128'(wb_valid), 128'(0));
        wb_ready = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
